// File: rtl/dsram_arbiter.sv
// dsram_arbiter: shares one single-port data SRAM between the EX-stage port (m0) and an auxiliary port (m1).
//   clk, resetn (async, active-low); m0_*/m1_* request inputs (req, wr, wstrb, addr, wdata);
//   m0_addr_ok/m1_addr_ok grant pulses; m0_data_ok/m1_data_ok plus m0_rdata/m1_rdata one cycle later;
//   data_sram_* SRAM port. Default build: fixed priority to m0 with a starvation counter for m1.
//   Define DSRAM_ARB_RR_EN for round-robin arbitration instead.
module dsram_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [3:0]  m0_wstrb,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_addr_ok,
  output logic        m0_data_ok,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [3:0]  m1_wstrb,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic        m1_addr_ok,
  output logic        m1_data_ok,
  output logic [31:0] m1_rdata,
  output logic        data_sram_en,
  output logic [3:0]  data_sram_we,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic [31:0] data_sram_rdata
);
  logic r_resp_vld, r_resp_id, r_resp_wr;
  logic w_grant0, w_grant1, w_any, w_wr;
`ifdef DSRAM_ARB_RR_EN
  logic r_last_grant;
  // On a tie the port that did not win last time goes next; reset value 1 lets m0 go first.
  assign w_grant1 = resetn & m1_req & (~m0_req | ~r_last_grant);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_last_grant <= 1'b1;
    else if (w_any) r_last_grant <= w_grant1;
`else
  localparam logic [3:0] SMAX = 4'(STARVE_MAX);
  logic [3:0] r_starve_cnt;
  assign w_grant1 = resetn & m1_req & (~m0_req | r_starve_cnt == SMAX);
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) r_starve_cnt <= 4'd0;
    else if (w_grant1 | ~m1_req) r_starve_cnt <= 4'd0;
    else if (w_grant0 && r_starve_cnt != SMAX) r_starve_cnt <= r_starve_cnt + 4'd1;
`endif
  // resetn is folded into the grants so every combinational output is forced low during reset.
  assign w_grant0 = resetn & m0_req & ~w_grant1;
  assign w_any = w_grant0 | w_grant1;
  assign w_wr = (w_grant0 & m0_wr) | (w_grant1 & m1_wr);
  assign m0_addr_ok = w_grant0;
  assign m1_addr_ok = w_grant1;
  assign data_sram_en = w_any;
  assign data_sram_we = w_grant1 ? (m1_wr ? m1_wstrb : 4'b0000) : w_grant0 ? (m0_wr ? m0_wstrb : 4'b0000) : 4'b0000;
  assign data_sram_addr = w_grant1 ? m1_addr : w_grant0 ? m0_addr : 32'h0;
  assign data_sram_wdata = w_grant1 ? m1_wdata : w_grant0 ? m0_wdata : 32'h0;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      r_resp_vld <= 1'b0;
      r_resp_id <= 1'b0;
      r_resp_wr <= 1'b0;
    end else begin
      r_resp_vld <= w_any;
      r_resp_id <= w_grant1;
      r_resp_wr <= w_wr;
    end
  assign m0_data_ok = r_resp_vld & ~r_resp_id;
  assign m1_data_ok = r_resp_vld & r_resp_id;
  assign m0_rdata = (m0_data_ok & ~r_resp_wr) ? data_sram_rdata : 32'h0;
  assign m1_rdata = (m1_data_ok & ~r_resp_wr) ? data_sram_rdata : 32'h0;
endmodule

// File: tb/tb_dsram_arbiter.sv
// tb_dsram_arbiter: randomized scoreboard bench for dsram_arbiter with a behavioural SRAM.
module tb_dsram_arbiter;
  localparam int SM = 4;
  logic clk = 1'b0, resetn = 1'b0;
  logic m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
  logic [3:0] m0_wstrb = 0, m1_wstrb = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic m0_addr_ok, m0_data_ok, m1_addr_ok, m1_data_ok, data_sram_en;
  logic [31:0] m0_rdata, m1_rdata, data_sram_addr, data_sram_wdata, data_sram_rdata;
  logic [3:0] data_sram_we;
  always #5 clk = ~clk;
  dsram_arbiter #(.STARVE_MAX(SM)) dut (
    .clk(clk), .resetn(resetn),
    .m0_req(m0_req), .m0_wr(m0_wr), .m0_wstrb(m0_wstrb), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_addr_ok(m0_addr_ok), .m0_data_ok(m0_data_ok), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_wr(m1_wr), .m1_wstrb(m1_wstrb), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_addr_ok(m1_addr_ok), .m1_data_ok(m1_data_ok), .m1_rdata(m1_rdata),
    .data_sram_en(data_sram_en), .data_sram_we(data_sram_we), .data_sram_addr(data_sram_addr),
    .data_sram_wdata(data_sram_wdata), .data_sram_rdata(data_sram_rdata)
  );
  logic [31:0] sram [256];
  logic [31:0] ref_mem [256];
  always @(posedge clk)
    if (data_sram_en) begin
      data_sram_rdata <= sram[data_sram_addr[9:2]];
      for (int b = 0; b < 4; b++)
        if (data_sram_we[b]) sram[data_sram_addr[9:2]][8*b +: 8] <= data_sram_wdata[8*b +: 8];
    end
  typedef struct { int due; logic id; logic [31:0] rd; } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cyc = 0, losses = 0, last_port = 1;
  logic mg0 = 0, mg1 = 0;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(string name, logic [103:0] act, logic [103:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask
  always @(negedge clk) begin : predictor
    logic [3:0] ewe;
    logic [31:0] ea, ed;
    logic ewr;
    if (!resetn) begin
      mg0 = 0;
      mg1 = 0;
    end else begin
`ifdef DSRAM_ARB_RR_EN
      mg1 = m1_req && (!m0_req || last_port == 0);
`else
      mg1 = m1_req && (!m0_req || losses >= SM);
`endif
      mg0 = m0_req && !mg1;
      ewr = mg1 ? m1_wr : mg0 ? m0_wr : 1'b0;
      ea = mg1 ? m1_addr : mg0 ? m0_addr : 32'h0;
      ed = mg1 ? m1_wdata : mg0 ? m0_wdata : 32'h0;
      ewe = ewr ? (mg1 ? m1_wstrb : m0_wstrb) : 4'h0;
      check("drive", {m0_addr_ok, m1_addr_ok, data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata},
            {mg0, mg1, mg0 | mg1, ewe, ea, ed});
      if (mg0 || mg1) begin
        q.push_back('{due: cyc + 1, id: mg1, rd: ewr ? 32'h0 : ref_mem[ea[9:2]]});
        for (int b = 0; b < 4; b++) if (ewe[b]) ref_mem[ea[9:2]][8*b +: 8] = ed[8*b +: 8];
        last_port = mg1 ? 1 : 0;
      end
      losses = (mg1 || !m1_req) ? 0 : (losses + 1 > SM ? SM : losses + 1);
    end
  end
  always @(negedge clk) begin : monitor
    exp_t e;
    if (resetn) begin
      if (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        check("resp", {m0_data_ok, m1_data_ok, m0_rdata, m1_rdata},
              {!e.id, e.id, e.id ? 32'h0 : e.rd, e.id ? e.rd : 32'h0});
      end else
        check("idle_resp", {m0_data_ok, m1_data_ok, m0_rdata, m1_rdata}, 66'h0);
    end
  end
  task automatic drive0(logic r, logic w, logic [3:0] s, logic [31:0] a, logic [31:0] d);
    m0_req = r; m0_wr = w; m0_wstrb = s; m0_addr = a; m0_wdata = d;
  endtask
  task automatic drive1(logic r, logic w, logic [3:0] s, logic [31:0] a, logic [31:0] d);
    m1_req = r; m1_wr = w; m1_wstrb = s; m1_addr = a; m1_wdata = d;
  endtask
  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic all_zero(string name);
    check(name, {m0_addr_ok, m0_data_ok, m0_rdata, m1_addr_ok, m1_data_ok, m1_rdata,
                 data_sram_en, data_sram_we, data_sram_addr, data_sram_wdata}, 104'h0);
  endtask
  initial begin
    int tally;
    for (int i = 0; i < 256; i++) begin
      sram[i] = (i * 32'h01010101) ^ 32'hA5A50000;
      ref_mem[i] = sram[i];
    end
    sram[8'h40] = 32'hDEADBEEF;
    ref_mem[8'h40] = 32'hDEADBEEF;
    drive0(1, 1, 4'hF, 32'h10, 32'h1);
    #1 all_zero("reset_outputs");
    step(3);
    #1 resetn = 1;
    drive0(0, 0, 0, 0, 0);
    step(1);
    drive0(1, 0, 4'h0, 32'h100, 0);
    step(1);
    drive0(0, 0, 0, 0, 0);
    step(1);
    drive1(1, 1, 4'b0011, 32'h20, 32'h1234ABCD);
    step(1);
    drive1(0, 0, 0, 0, 0);
    step(2);
    tally = 0;
    drive0(1, 0, 0, 32'h104, 0);
    drive1(1, 0, 0, 32'h108, 0);
    repeat (20) begin
      @(negedge clk);
      tally += m1_addr_ok ? 1 : 0;
    end
`ifdef DSRAM_ARB_RR_EN
    check("m1_grants", 104'(tally), 104'd10);
`else
    check("m1_grants", 104'(tally), 104'd4);
`endif
    step(1);
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    step(2);
    drive0(1, 1, 4'hF, 32'h40, 32'hCAFEF00D);
    step(1);
    drive0(0, 0, 0, 0, 0);
    drive1(1, 0, 0, 32'h40, 0);
    step(1);
    drive1(0, 0, 0, 0, 0);
    step(2);
    drive0(1, 0, 0, 32'h8, 0);
    drive1(1, 1, 4'hC, 32'hC, 32'h55667788);
    step(2);
    #2 resetn = 0;
    #1 all_zero("async_reset_outputs");
    q.delete();
    losses = 0;
    last_port = 1;
    step(2);
    #1 resetn = 1;
    step(8);
    for (int i = 0; i < 2000; i++) begin
      if (!m0_req || mg0) begin
        if ($urandom_range(0, 3) != 0)
          drive0(1, 1'($urandom_range(0, 1)), 4'($urandom), {22'h0, 8'($urandom), 2'b00}, $urandom);
        else
          drive0(0, 0, 0, 0, 0);
      end
      if (!m1_req || mg1) begin
        if ($urandom_range(0, 1) != 0)
          drive1(1, 1'($urandom_range(0, 1)), 4'($urandom), {22'h0, 8'($urandom), 2'b00}, $urandom);
        else
          drive1(0, 0, 0, 0, 0);
      end
      step(1);
    end
    drive0(0, 0, 0, 0, 0);
    drive1(0, 0, 0, 0, 0);
    step(3);
    check("queue_drained", 104'(q.size()), 104'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dsram_arbiter.md
Name: dsram_arbiter

Overview:
- Shares the single-port data SRAM between two requesters.
- Requester 0 is the pipeline EX-stage load/store port. Requester 1 is an auxiliary port (debug/DMA-style).
- Grants at most one access per cycle and drives the SRAM port. Routes the one-cycle-latency SRAM response back to the requester that issued the access.
- Fixed priority to requester 0, with a starvation counter that guarantees requester 1 progress.

Parameters:
- STARVE_MAX, 4: consecutive cycles requester 1 may lose arbitration before it is forced to win. Legal range 1..15.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- m0_req  in  1  requester 0 access request
- m0_wr  in  1  1 = write, 0 = read
- m0_wstrb  in  4  byte write strobes (ignored for reads)
- m0_addr  in  32  byte address
- m0_wdata  in  32  write data
- m0_addr_ok  out  1  request 0 accepted this cycle
- m0_data_ok  out  1  response for an accepted request 0
- m0_rdata  out  32  read data, valid with m0_data_ok
- m1_req, m1_wr, m1_wstrb, m1_addr, m1_wdata  in  1/1/4/32/32  requester 1 request, same meaning as requester 0
- m1_addr_ok, m1_data_ok  out  1  requester 1 accept / response
- m1_rdata  out  32  requester 1 read data
- data_sram_en  out  1  SRAM enable
- data_sram_we  out  4  SRAM byte write enables
- data_sram_addr  out  32  SRAM address
- data_sram_wdata  out  32  SRAM write data
- data_sram_rdata  in  32  SRAM read data, one cycle after an enabled read

Behaviour:
- Clock is clk; reset is resetn, asynchronous, active-low.
- Reset clears all state: resp_vld=0, resp_id=0, resp_wr=0, starve_cnt=0.
- While resetn=0, all outputs are forced to 0, including the combinational ones.
- Arbitration is combinational in the request cycle:
  - grant1 = m1_req & (~m0_req | starve_cnt==STARVE_MAX); grant0 = m0_req & ~grant1.
  - mX_addr_ok = grantX. Both are never high together.
- SRAM drive:
  - data_sram_en = grant0|grant1.
  - data_sram_we = granted wr ? granted wstrb : 4'b0000.
  - addr and wdata are muxed from the granted port.
  - With no grant: addr=0, wdata=0, we=0.
- Response tracking, registered at posedge:
  - resp_vld <= grant0|grant1; resp_id <= grant1; resp_wr <= granted wr.
  - The SRAM is accessed in cycle N; mX_data_ok pulses for exactly one cycle in N+1.
  - mX_data_ok = resp_vld & (resp_id==X).
  - mX_rdata = data_sram_rdata when mX_data_ok & ~resp_wr, else 32'h0.
  - Writes also receive data_ok (write acknowledge) with rdata=0.
- No response backpressure; requesters must accept data_ok when it arrives.
- Back-to-back grants are allowed every cycle. The response for cycle N and the grant for cycle N+1 coexist.
- Request fields must stay stable while mX_req=1 and mX_addr_ok=0. The arbiter does not latch requests.
- Starvation counter (4 bits):
  - Increments when m1_req & grant0.
  - Clears to 0 when grant1 or ~m1_req.
  - Saturates at STARVE_MAX; it never exceeds it.
- Simultaneous requests with starve_cnt<STARVE_MAX: requester 0 wins.
- Simultaneous requests with starve_cnt==STARVE_MAX: requester 1 wins and the counter clears next cycle.
- Reset asserted between grant and response: the pending data_ok is dropped. After reset release, the first cycle shows no data_ok.

Optional Feature:
- Macro: DSRAM_ARB_RR_EN.
- Defined:
  - Starvation counter is removed. A 1-bit last_grant register (reset 1) selects round-robin.
  - On a simultaneous request, the port not granted last wins. last_grant updates on every grant.
  - A single requester always wins immediately.
- Undefined: fixed priority plus starvation counter as above.
- Handshake, latency and response routing are identical in both builds.

Test Plan:
- m0 read, addr 0x100 alone in cycle N → N: m0_addr_ok=1, data_sram_en=1, we=0000, addr=0x100. N+1: m0_data_ok=1, m0_rdata=0xDEADBEEF (SRAM model value), m1_data_ok=0.
- m1 write, addr 0x20, wstrb 0011, wdata 0x1234ABCD alone → data_sram_we=0011, wdata=0x1234ABCD. Next cycle: m1_data_ok=1, m1_rdata=0.
- m0_req and m1_req held high continuously, STARVE_MAX=4 → grants 0,0,0,0,1,0,0,0,0,1…; m1_addr_ok every 5th cycle; starve_cnt=0 after each m1 grant.
- m0 granted at N, m1 alone at N+1 → m0_data_ok at N+1, m1_data_ok at N+2, no overlap; data_sram_en high at N and N+1.
- Drop resetn asynchronously mid-cycle after a grant → all outputs 0 immediately. No data_ok after release. starve_cnt=0.
- With DSRAM_ARB_RR_EN, both requesting continuously from reset → grants 0,1,0,1… starting with m0.
